// File: rtl/bus_ram_responder.sv
// Word-organised RAM on the CPU memory bus: stalls each access for WAIT_CYCLES
// extra cycles via waitrequest, applies byte-enabled writes, flags bad requests.
module bus_ram_responder #(
   parameter int unsigned ADDR_BITS     = 10,
   parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
   parameter int unsigned WAIT_CYCLES   = 1,
   parameter string       RAM_INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        bus_error
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic [ADDR_BITS-1:0] idx;
      logic [3:0]           be;
      logic [31:0]          wdata;
      logic                 wr;
      logic                 err;
   } req_t;

   logic [31:0] mem [2**ADDR_BITS];

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   req_t        req_q, req_live, req_src;
   logic [31:0] offset;
   logic        accept;

   // Cleared once at time 0; contents survive reset.
   initial begin
      for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] = '0;
   end

   assign offset = address - BASE_ADDR;

   // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
   always_comb begin
      req_live.idx   = offset[ADDR_BITS+1:2];
      req_live.be    = byteenable;
      req_live.wdata = writedata;
      req_live.wr    = write;
      req_live.err   = (read & write) | (address[1:0] != 2'b00) |
                       ((offset >> (ADDR_BITS + 2)) != 32'd0);
   end

   assign accept      = (state == IDLE) & (read | write);
   assign waitrequest = (read | write) & (state != DONE);
   assign req_src     = accept ? req_live : req_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (accept) begin
            cnt_nxt   = 4'(WAIT_CYCLES);
            state_nxt = (WAIT_CYCLES == 0) ? DONE : BUSY;
         end
         BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req_q     <= '0;
         readdata  <= '0;
         bus_error <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            req_q <= req_live;
            if (req_live.err) bus_error <= 1'b1;
         end
         // With zero wait states DONE is entered straight from the accept edge,
         // so the read uses the live request rather than the latched copy.
         if (state_nxt == DONE && state != DONE)
            readdata <= (req_src.wr | req_src.err) ? 32'd0 : mem[req_src.idx];
      end
   end

   // Commit on the edge leaving DONE; an async reset drops state first and discards it.
   always_ff @(posedge clk) begin
      if (state == DONE && req_q.wr && !req_q.err) begin
         for (int i = 0; i < 4; i++)
            if (req_q.be[i]) mem[req_q.idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: a WAIT_CYCLES=1 instance checked against a word-array
// model, plus a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_bus_ram_responder;
   localparam logic [31:0] BASE = 32'hBFC00000;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       rd = '0, wr = '0;
   logic [1:0][31:0] addr = '0, wdat = '0;
   logic [1:0][3:0]  be = '0;
   logic [1:0][31:0] rdat;
   logic [1:0]       wreq, berr;

   int tests = 0;
   int fails = 0;

   logic [31:0] ref_mem [1024];
   bit          ref_err = 1'b0;

   always #5 clk = ~clk;

   bus_ram_responder #(.WAIT_CYCLES(0)) u0 (
      .clk(clk), .reset_n(reset_n), .address(addr[0]), .read(rd[0]), .write(wr[0]),
      .byteenable(be[0]), .writedata(wdat[0]), .waitrequest(wreq[0]),
      .readdata(rdat[0]), .bus_error(berr[0]));

   bus_ram_responder #(.WAIT_CYCLES(1)) u1 (
      .clk(clk), .reset_n(reset_n), .address(addr[1]), .read(rd[1]), .write(wr[1]),
      .byteenable(be[1]), .writedata(wdat[1]), .waitrequest(wreq[1]),
      .readdata(rdat[1]), .bus_error(berr[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // CPU-side access: present request, hold it until waitrequest drops, then release.
   task automatic run_op(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd,
                         output logic [31:0] rdv, output int hi);
      @(posedge clk); #1;
      rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wdat[d] = wd;
      hi = 0;
      rdv = '0;
      while (hi <= 40) begin
         @(negedge clk);
         if (!wreq[d]) break;
         hi++;
      end
      if (hi > 40) begin
         tests++; fails++;
         $display("FAIL timeout dut%0d: waitrequest never dropped", d);
      end
      rdv = rdat[d];
      @(posedge clk); #1;
      rd[d] = 1'b0; wr[d] = 1'b0;
   endtask

   function automatic bit addr_err(input logic r, input logic w, input logic [31:0] a);
      return (r && w) || (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'd4096);
   endfunction

   // Access on the WAIT_CYCLES=1 instance, predicted from the word-array model.
   task automatic check_op(input string name, input logic r, input logic w,
                           input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] wd, output logic [31:0] rdv);
      int          hi;
      bit          e;
      logic [31:0] off, exp_rd;
      e   = addr_err(r, w, a);
      off = a - BASE;
      exp_rd = (e || w) ? 32'd0 : ref_mem[off[11:2]];
      run_op(1, r, w, a, b, wd, rdv, hi);
      if (e) ref_err = 1'b1;
      if (!e && w)
         for (int i = 0; i < 4; i++)
            if (b[i]) ref_mem[off[11:2]][8*i +: 8] = wd[8*i +: 8];
      chk({name, " rdata"}, rdv, exp_rd);
      chk({name, " stall"}, 32'(hi), 32'd2);
      chk({name, " bus_error"}, {31'd0, berr[1]}, {31'd0, ref_err});
   endtask

   typedef struct {
      logic        r, w;
      logic [31:0] a;
      logic [3:0]  b;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [31:0] rdv;
      int          hi;
      logic [3:0]  wseq;

      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      tbl[0] = '{1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'h11223344, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'hBFC00010, 4'b0101, 32'hAABBCCDD, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'hBFC00010, 4'h0, 32'h0, 32'h11BB33DD};
      tbl[3] = '{1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'h24020005, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, 32'h24020005};
      tbl[5] = '{1'b0, 1'b1, 32'hBFC00004, 4'b0011, 32'h1234BEEF, 32'h0};
      tbl[6] = '{1'b1, 1'b0, 32'hBFC00004, 4'h0, 32'h0, 32'h0000BEEF};

      // Reset state; waitrequest follows read|write while held in reset
      rd[1] = 1'b1;
      #22;
      chk("reset readdata0", rdat[0], 32'h0);
      chk("reset readdata1", rdat[1], 32'h0);
      chk("reset bus_error", {30'd0, berr}, 32'h0);
      chk("reset waitrequest", {30'd0, wreq}, 32'h2);
      rd[1] = 1'b0;
      @(negedge clk); reset_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         check_op($sformatf("tbl%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].wd, rdv);
         chk($sformatf("tbl%0d expect", i), rdv, tbl[i].exp);
      end

      // WAIT_CYCLES=1 read held: 2 high, 1 low with data, then IDLE re-raises it
      @(posedge clk); #1;
      rd[1] = 1'b1; addr[1] = 32'hBFC00000;
      for (int i = 3; i >= 0; i--) begin
         @(negedge clk);
         wseq[i] = wreq[1];
         if (i == 1) chk("held read data", rdat[1], 32'h24020005);
      end
      chk("held read waitrequest seq", {28'd0, wseq}, 32'hD);
      @(posedge clk); #1; rd[1] = 1'b0;
      repeat (3) @(posedge clk);

      // WAIT_CYCLES=0 back-to-back reads
      run_op(0, 1'b0, 1'b1, BASE, 4'hF, 32'hA5A50001, rdv, hi);
      chk("w0 write stall", 32'(hi), 32'd1);
      run_op(0, 1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'h5A5A0002, rdv, hi);
      chk("w0 write2 stall", 32'(hi), 32'd1);
      @(posedge clk); #1;
      rd[0] = 1'b1; addr[0] = BASE;
      @(negedge clk); wseq[3] = wreq[0];
      @(negedge clk); wseq[2] = wreq[0];
      chk("b2b read0 data", rdat[0], 32'hA5A50001);
      @(posedge clk); #1; addr[0] = BASE + 32'd4;
      @(negedge clk); wseq[1] = wreq[0];
      @(negedge clk); wseq[0] = wreq[0];
      chk("b2b read1 data", rdat[0], 32'h5A5A0002);
      chk("b2b waitrequest seq", {28'd0, wseq}, 32'hA);
      @(posedge clk); #1; rd[0] = 1'b0;

      // Randomized valid traffic above word 16
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = BASE + (32'($urandom_range(16, 1023)) << 2);
         if ($urandom_range(0, 1) == 1)
            check_op("rand write", 1'b0, 1'b1, a, 4'($urandom), $urandom, rdv);
         else
            check_op("rand read", 1'b1, 1'b0, a, 4'($urandom), $urandom, rdv);
      end

      // Error cases
      check_op("oor read", 1'b1, 1'b0, 32'h00000000, 4'h0, 32'h0, rdv);
      check_op("after err read", 1'b1, 1'b0, BASE, 4'h0, 32'h0, rdv);
      check_op("rw both", 1'b1, 1'b1, BASE + 32'h20, 4'hF, 32'hFFFFFFFF, rdv);
      check_op("rw both readback", 1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0, rdv);
      check_op("misaligned write", 1'b0, 1'b1, BASE + 32'h11, 4'hF, 32'hFFFFFFFF, rdv);
      check_op("misaligned readback", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0, rdv);
      check_op("top oor write", 1'b0, 1'b1, BASE + 32'd4096, 4'hF, 32'hFFFFFFFF, rdv);

      // Reset asserted while BUSY with a write to word 2
      @(posedge clk); #1;
      wr[1] = 1'b1; addr[1] = BASE + 32'h8; be[1] = 4'hF; wdat[1] = 32'hDEADBEEF;
      @(posedge clk); #1;
      reset_n = 1'b0;
      wr[1] = 1'b0;
      #1;
      chk("midreset readdata", rdat[1], 32'h0);
      chk("midreset bus_error", {31'd0, berr[1]}, 32'h0);
      chk("midreset waitrequest", {31'd0, wreq[1]}, 32'h0);
      @(negedge clk); reset_n = 1'b1;
      ref_err = 1'b0;
      check_op("word2 after reset", 1'b1, 1'b0, BASE + 32'h8, 4'h0, 32'h0, rdv);

      // Inputs changed while BUSY must not affect the latched write
      @(posedge clk); #1;
      wr[1] = 1'b1; addr[1] = BASE + 32'h30; be[1] = 4'hF; wdat[1] = 32'h12345678;
      @(posedge clk); #1;
      addr[1] = BASE + 32'h34; wdat[1] = 32'hCAFEF00D; be[1] = 4'h1;
      hi = 0;
      while (hi <= 40) begin
         @(negedge clk);
         if (!wreq[1]) break;
         hi++;
      end
      if (hi > 40) begin
         tests++; fails++;
         $display("FAIL timeout busy-change write");
      end
      @(posedge clk); #1; wr[1] = 1'b0;
      ref_mem[12] = 32'h12345678;
      check_op("latched word12", 1'b1, 1'b0, BASE + 32'h30, 4'h0, 32'h0, rdv);
      chk("latched word12 value", rdv, 32'h12345678);
      check_op("untouched word13", 1'b1, 1'b0, BASE + 32'h34, 4'h0, 32'h0, rdv);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end
endmodule
